jtag_scan_sequencer: RTL and testbench

JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

---
 rtl/jtag_pkg.sv | 45 ++++
 rtl/jtag_scan_sequencer_shifter.sv | 55 +++++
 rtl/jtag_scan_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_jtag_scan_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: sequencer command opcodes, IEEE 1149.1 TAP state
// encodings (shared with the TAP controller) and the fixed sequence lengths.
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_TAP_RESET = 2'd0,
    OP_IR_SCAN   = 2'd1,
    OP_DR_SCAN   = 2'd2,
    OP_RSVD      = 2'd3
  } jtag_op_e;

  typedef enum logic [3:0] {
    TAP_EX2_DR   = 4'h0,
    TAP_EX1_DR   = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EX2_IR   = 4'h8,
    TAP_EX1_IR   = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RST_SEQ = 3'd1,
    S_PRE     = 3'd2,
    S_SHIFT   = 3'd3,
    S_POST    = 3'd4,
    S_RESP    = 3'd5
  } seq_state_e;

  localparam int unsigned RST_SEQ_LEN = 6;
  localparam int unsigned PRE_DR_LEN  = 3;
  localparam int unsigned PRE_IR_LEN  = 4;
  localparam int unsigned POST_LEN    = 2;

endpackage

// File: rtl/jtag_scan_sequencer_shifter.sv
// Scan data path: TDI shift-out register, TDO capture register and bit counter.
// Exposes next-cycle tdi/count so the sequencer can keep its pin outputs registered.
module scan_shifter
  import jtag_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  logic              tdo,
  output logic              next_tdi,
  output logic [LEN_W-1:0]  bit_cnt,
  output logic [LEN_W-1:0]  next_bit_cnt,
  output logic [DATA_W-1:0] capture
);

  logic [DATA_W-1:0] out_r;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] out_shifted_s;
  logic [DATA_W-1:0] tdo_bit_s;
  logic [LEN_W-1:0]  cnt_r;

  assign out_shifted_s = out_r >> 1;
  assign tdo_bit_s     = {{(DATA_W-1){1'b0}}, tdo} << cnt_r;
  assign next_tdi      = shift ? out_shifted_s[0] : out_r[0];
  assign next_bit_cnt  = shift ? (cnt_r + {{(LEN_W-1){1'b0}}, 1'b1}) : cnt_r;
  assign bit_cnt       = cnt_r;
  assign capture       = in_r;

  // Load clears the capture so bits at len and above read back as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r <= {DATA_W{1'b0}};
      in_r  <= {DATA_W{1'b0}};
      cnt_r <= {LEN_W{1'b0}};
    end else if (load) begin
      out_r <= load_data;
      in_r  <= {DATA_W{1'b0}};
      cnt_r <= {LEN_W{1'b0}};
    end else if (shift) begin
      out_r <= out_shifted_s;
      in_r  <= in_r | tdo_bit_s;
      cnt_r <= next_bit_cnt;
    end else begin
      out_r <= out_r;
      in_r  <= in_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/jtag_scan_sequencer.sv
// JTAG scan sequencer: turns TAP_RESET / IR_SCAN / DR_SCAN commands into tms/tdi
// streams for a target TAP and returns captured TDO bits as a response.
module jtag_scan_sequencer
  import jtag_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              tap_enable,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(DATA_W);

  seq_state_e       state_r, state_n;
  jtag_op_e         op_r, op_n;
  logic [LEN_W-1:0] len_r, len_n;
  logic [2:0]       cnt_r, cnt_n;
  logic             synced_r, synced_n;
  logic             tap_enable_r, tap_enable_n;
  logic             tms_r, tms_n;
  logic             tdi_r, tdi_n;
  logic             rsp_valid_r, rsp_valid_n;
  logic             rsp_err_r, rsp_err_n;
  logic             load_s, shift_s, bad_cmd_s, last_bit_s;
  logic             next_tdi_s;
  logic [LEN_W-1:0] bit_cnt_s, next_bit_cnt_s;
  logic [2:0]       pre_last_s;

  assign bad_cmd_s  = (cmd_len == {LEN_W{1'b0}}) || ({1'b0, cmd_len} > MAX_LEN) ||
                      (cmd_op == OP_RSVD);
  assign pre_last_s = (op_r == OP_IR_SCAN) ? 3'(PRE_IR_LEN - 1) : 3'(PRE_DR_LEN - 1);
  assign last_bit_s = (bit_cnt_s == (len_r - {{(LEN_W-1){1'b0}}, 1'b1}));

  // Next state, then pin values for the state being entered so outputs stay registered
  always_comb begin
    state_n   = state_r;
    op_n      = op_r;
    len_n     = len_r;
    cnt_n     = cnt_r;
    synced_n  = synced_r;
    rsp_err_n = rsp_err_r;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          load_s    = 1'b1;
          op_n      = jtag_op_e'(cmd_op);
          len_n     = cmd_len;
          cnt_n     = 3'd0;
          rsp_err_n = bad_cmd_s;
          if (bad_cmd_s) begin
            state_n = S_RESP;
          end else if ((cmd_op == OP_TAP_RESET) || !synced_r) begin
            state_n = S_RST_SEQ;
          end else begin
            state_n = S_PRE;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RST_SEQ: begin
        if (cnt_r == 3'(RST_SEQ_LEN - 1)) begin
          synced_n = 1'b1;
          cnt_n    = 3'd0;
          state_n  = (op_r == OP_TAP_RESET) ? S_RESP : S_PRE;
        end else begin
          cnt_n = cnt_r + 3'd1;
        end
      end
      S_PRE: begin
        if (cnt_r == pre_last_s) begin
          cnt_n   = 3'd0;
          state_n = S_SHIFT;
        end else begin
          cnt_n = cnt_r + 3'd1;
        end
      end
      S_SHIFT: begin
        shift_s = 1'b1;
        if (last_bit_s) begin
          cnt_n   = 3'd0;
          state_n = S_POST;
        end else begin
          state_n = S_SHIFT;
        end
      end
      S_POST: begin
        if (cnt_r == 3'(POST_LEN - 1)) begin
          cnt_n   = 3'd0;
          state_n = S_RESP;
        end else begin
          cnt_n = cnt_r + 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_err_n = 1'b0;
          state_n   = S_IDLE;
        end else begin
          state_n = S_RESP;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    tap_enable_n = 1'b0;
    tms_n        = 1'b0;
    tdi_n        = 1'b0;
    rsp_valid_n  = (state_n == S_RESP);
    case (state_n)
      S_RST_SEQ: begin
        tap_enable_n = 1'b1;
        tms_n        = (cnt_n != 3'(RST_SEQ_LEN - 1));
      end
      S_PRE: begin
        tap_enable_n = 1'b1;
        tms_n        = (op_n == OP_IR_SCAN) ? (cnt_n < 3'd2) : (cnt_n == 3'd0);
      end
      S_SHIFT: begin
        tap_enable_n = 1'b1;
        tms_n        = (next_bit_cnt_s == (len_r - {{(LEN_W-1){1'b0}}, 1'b1}));
        tdi_n        = next_tdi_s;
      end
      S_POST: begin
        tap_enable_n = 1'b1;
        tms_n        = (cnt_n == 3'd0);
      end
      default: begin
        tap_enable_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      op_r         <= OP_TAP_RESET;
      len_r        <= {LEN_W{1'b0}};
      cnt_r        <= 3'd0;
      synced_r     <= 1'b0;
      tap_enable_r <= 1'b0;
      tms_r        <= 1'b0;
      tdi_r        <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else begin
      state_r      <= state_n;
      op_r         <= op_n;
      len_r        <= len_n;
      cnt_r        <= cnt_n;
      synced_r     <= synced_n;
      tap_enable_r <= tap_enable_n;
      tms_r        <= tms_n;
      tdi_r        <= tdi_n;
      rsp_valid_r  <= rsp_valid_n;
      rsp_err_r    <= rsp_err_n;
    end
  end

  scan_shifter #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .load         (load_s),
    .load_data    (cmd_data),
    .shift        (shift_s),
    .tdo          (tdo),
    .next_tdi     (next_tdi_s),
    .bit_cnt      (bit_cnt_s),
    .next_bit_cnt (next_bit_cnt_s),
    .capture      (rsp_data)
  );

  assign cmd_ready  = (state_r == S_IDLE) && !reset;
  assign tap_enable = tap_enable_r;
  assign tms        = tms_r;
  assign tdi        = tdi_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Bench for jtag_scan_sequencer: vector table plus a TAP state model and a
// scoreboard of expected responses, tms streams and cycle counts.
module tb_jtag_scan_sequencer;
  import jtag_pkg::*;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 6;

  logic              clk = 1'b0;
  logic              reset, cmd_valid, cmd_ready, tap_enable, tms, tdi, tdo;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [1:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data, rsp_data;
  int                tdo_mode;
  int                total = 0;
  int                bad = 0;
  logic              synced_m;
  tap_state_e        tap_st;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    int          mode;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cycles;
    logic [63:0] tms_seq;
    int          shift_cycles;
  } exp_t;

  vec_t vecs[11];
  exp_t sb_q[$];

  always #5 clk = ~clk;

  assign tdo = (tdo_mode == 1) ? 1'b1 : tdi;

  jtag_scan_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .cmd_data   (cmd_data),
    .tap_enable (tap_enable),
    .tms        (tms),
    .tdi        (tdi),
    .tdo        (tdo),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  function automatic tap_state_e tap_step(input tap_state_e s, input logic m);
    case (s)
      TAP_TLR:      return m ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      return m ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   return m ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   return m ? TAP_EX1_DR   : TAP_SHIFT_DR;
      TAP_SHIFT_DR: return m ? TAP_EX1_DR   : TAP_SHIFT_DR;
      TAP_EX1_DR:   return m ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: return m ? TAP_EX2_DR   : TAP_PAUSE_DR;
      TAP_EX2_DR:   return m ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   return m ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   return m ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   return m ? TAP_EX1_IR   : TAP_SHIFT_IR;
      TAP_SHIFT_IR: return m ? TAP_EX1_IR   : TAP_SHIFT_IR;
      TAP_EX1_IR:   return m ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: return m ? TAP_EX2_IR   : TAP_PAUSE_IR;
      TAP_EX2_IR:   return m ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   return m ? TAP_SEL_DR   : TAP_RTI;
      default:      return TAP_TLR;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_bit(inout exp_t e, input logic b);
    e.tms_seq = {e.tms_seq[62:0], b};
    e.cycles++;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance
  task automatic drive_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    int waited = 0;
    while (!cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready_before_cmd", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         input int mode, input logic [31:0] exp_data, input logic exp_err,
                         input int stall);
    exp_t        e;
    logic [63:0] act_tms;
    int          act_n, shifts, cyc, rsp_cyc;
    logic        idle_bad, stable;
    e.data = exp_data; e.err = exp_err; e.cycles = 0; e.tms_seq = 64'd0; e.shift_cycles = 0;
    if (!exp_err) begin
      if (!synced_m || op == 2'd0)
        for (int i = 0; i < 6; i++) push_bit(e, i < 5);
      if (op != 2'd0) begin
        if (op == 2'd1) begin
          push_bit(e, 1'b1); push_bit(e, 1'b1); push_bit(e, 1'b0); push_bit(e, 1'b0);
        end else begin
          push_bit(e, 1'b1); push_bit(e, 1'b0); push_bit(e, 1'b0);
        end
        for (int i = 0; i < int'(len); i++) push_bit(e, i == int'(len) - 1);
        push_bit(e, 1'b1); push_bit(e, 1'b0);
        e.shift_cycles = int'(len);
      end
      synced_m = 1'b1;
    end
    sb_q.push_back(e);
    tdo_mode = mode;
    drive_cmd(op, len, data);
    cyc = 1; rsp_cyc = 0; act_tms = 64'd0; act_n = 0; shifts = 0; idle_bad = 1'b0;
    while (rsp_cyc == 0 && cyc < 200) begin
      if (rsp_valid) begin
        rsp_cyc = cyc;
      end else begin
        if (tap_enable) begin
          act_tms = {act_tms[62:0], tms};
          act_n++;
          if (tap_st == TAP_SHIFT_DR || tap_st == TAP_SHIFT_IR) shifts++;
          tap_st = tap_step(tap_st, tms);
        end else if (tms || tdi) begin
          idle_bad = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    e = sb_q.pop_front();
    check("rsp_latency", 64'(rsp_cyc), 64'(e.cycles + 1));
    check("tap_cycles", 64'(act_n), 64'(e.cycles));
    check("tms_stream", act_tms, e.tms_seq);
    check("shift_cycles", 64'(shifts), 64'(e.shift_cycles));
    check("idle_pins_low", 64'(idle_bad), 64'(0));
    check("tap_in_rti", 64'(tap_st), 64'(TAP_RTI));
    check("rsp_data", 64'(rsp_data), 64'(e.data));
    check("rsp_err", 64'(rsp_err), 64'(e.err));
    stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== e.data || rsp_err !== e.err || cmd_ready) stable = 1'b0;
    end
    if (stall > 0) check("rsp_held_during_stall", 64'(stable), 64'(1));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("cmd_ready_after_handshake", 64'(cmd_ready), 64'(1));
    check("rsp_valid_after_handshake", 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    vecs[0]  = '{2'd2, 6'd8,  32'h000000A5, 0, 32'h000000A5, 1'b0};
    vecs[1]  = '{2'd0, 6'd1,  32'h00000000, 0, 32'h00000000, 1'b0};
    vecs[2]  = '{2'd1, 6'd4,  32'h0000000E, 0, 32'h0000000E, 1'b0};
    vecs[3]  = '{2'd2, 6'd32, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{2'd2, 6'd0,  32'hFFFFFFFF, 1, 32'h00000000, 1'b1};
    vecs[5]  = '{2'd2, 6'd33, 32'hFFFFFFFF, 1, 32'h00000000, 1'b1};
    vecs[6]  = '{2'd3, 6'd8,  32'h000000FF, 1, 32'h00000000, 1'b1};
    vecs[7]  = '{2'd2, 6'd1,  32'h00000000, 1, 32'h00000001, 1'b0};
    vecs[8]  = '{2'd2, 6'd1,  32'h00000000, 1, 32'h00000001, 1'b0};
    vecs[9]  = '{2'd2, 6'd12, 32'h00000123, 1, 32'h00000FFF, 1'b0};
    vecs[10] = '{2'd1, 6'd7,  32'hFFFFFF55, 0, 32'h00000055, 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 6'd0; cmd_data = 32'd0;
    rsp_ready = 1'b0; tdo_mode = 0; synced_m = 1'b0; tap_st = TAP_TLR;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    check("reset_outputs", {60'd0, tap_enable, tms, tdi, rsp_valid}, 64'd0);
    check("reset_rsp", {31'd0, rsp_err, rsp_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

    for (int v = 0; v < 11; v++)
      run_cmd(vecs[v].op, vecs[v].len, vecs[v].data, vecs[v].mode,
              vecs[v].exp_data, vecs[v].exp_err, 0);

    // response back-pressure
    run_cmd(2'd2, 6'd8, 32'h0000003C, 0, 32'h0000003C, 1'b0, 10);

    // reset during SHIFT bit 5 of a synced DR scan: cycles 1-3 PRE, bit 5 on cycle 9
    tdo_mode = 0;
    drive_cmd(2'd2, 6'd8, 32'h000000FF);
    repeat (8) @(negedge clk);
    check("mid_scan_tap_enable", 64'(tap_enable), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", {60'd0, tap_enable, tms, tdi, rsp_valid}, 64'd0);
    check("abort_rsp", {31'd0, rsp_err, rsp_data}, 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'(0));
    reset = 1'b0;
    synced_m = 1'b0;
    @(negedge clk);
    check("abort_no_rsp", 64'(rsp_valid), 64'(0));
    run_cmd(2'd2, 6'd8, 32'h0000005A, 0, 32'h0000005A, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
